// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator sitting between decode and the
// ALU operand mux. Picks the mem-type or I-type immediate field, extends it to
// DATA_W (sign or zero), or joins it with upper bits held from a preceding
// prefix instruction. One-deep output register with valid/ready on both sides.
module imm_gen_pipe #(
    parameter int INSTR_W = 32,
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 17,
    parameter int SEL_BIT = 27,
    parameter int MEM_LSB = 0,
    parameter int I_LSB   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic              is_prefix,
    input  logic              zext,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] imm_out,
    output logic              imm_src,
    output logic              prefixed,
    output logic              pfx_pending,
    output logic              pfx_overwrite
);

    // Number of upper bits supplied by a prefix instruction.
    localparam int PFX_W = DATA_W - IMM_W;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state;
    logic [PFX_W-1:0]    pfx_value;

    logic                field_sel;
    logic [IMM_W-1:0]    mem_field;
    logic [IMM_W-1:0]    i_field;
    logic [IMM_W-1:0]    field;
    logic [PFX_W-1:0]    ext_bits;
    logic [DATA_W-1:0]   imm_next;
    logic                accept;
    logic                transfer;

    // Many instruction bits (opcode, registers) are of no interest here.
    logic                unused_instr_bits;
    assign unused_instr_bits = &{1'b0, instr};

    // The output slot is free when empty or being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign transfer = out_valid && out_ready;

    // The held state is itself a register, so the pending flag is registered.
    assign pfx_pending = (state == HOLD);

    // Field selection and width extension of the candidate immediate.
    always_comb begin
        field_sel = instr[SEL_BIT];
        mem_field = instr[MEM_LSB +: IMM_W];
        i_field   = instr[I_LSB +: IMM_W];
        field     = field_sel ? mem_field : i_field;
        ext_bits  = '0;
        if (state == HOLD) begin
            // A held prefix supplies the upper bits; zext has no meaning here.
            ext_bits = pfx_value;
        end else if (!zext) begin
            ext_bits = {PFX_W{field[IMM_W-1]}};
        end
        imm_next = {ext_bits, field};
    end

    // Prefix tracking FSM together with the output register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pfx_value     <= '0;
            out_valid     <= 1'b0;
            imm_out       <= '0;
            imm_src       <= 1'b0;
            prefixed      <= 1'b0;
            pfx_overwrite <= 1'b0;
        end else if (flush) begin
            // Drop whatever is in flight; imm_out and the prefix value are
            // left untouched since nothing downstream may look at them now.
            state         <= IDLE;
            out_valid     <= 1'b0;
            pfx_overwrite <= 1'b0;
        end else begin
            pfx_overwrite <= 1'b0;
            if (accept && is_prefix) begin
                pfx_value <= instr[PFX_W-1:0];
                state     <= HOLD;
                if (state == HOLD) begin
                    pfx_overwrite <= 1'b1;
                end
                // A prefix produces no result; the slot empties if drained.
                if (transfer) begin
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                out_valid <= 1'b1;
                imm_out   <= imm_next;
                imm_src   <= field_sel;
                prefixed  <= (state == HOLD);
                state     <= IDLE;
            end else if (transfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: directed vectors with literal expectations plus
// a behavioural model compared against the DUT on every falling edge.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        is_prefix = 1'b0;
    logic        zext = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, imm_src, prefixed, pfx_pending, pfx_overwrite;
    logic [31:0] imm_out;

    logic        d2_in_ready, d2_out_valid, d2_imm_src, d2_prefixed, d2_pfx_pending, d2_pfx_overwrite;
    logic [31:0] d2_imm_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .is_prefix(is_prefix), .zext(zext), .out_valid(out_valid),
        .out_ready(out_ready), .imm_out(imm_out), .imm_src(imm_src), .prefixed(prefixed),
        .pfx_pending(pfx_pending), .pfx_overwrite(pfx_overwrite)
    );

    imm_gen_pipe #(.I_LSB(4)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d2_in_ready),
        .instr(instr), .is_prefix(is_prefix), .zext(zext), .out_valid(d2_out_valid),
        .out_ready(out_ready), .imm_out(d2_imm_out), .imm_src(d2_imm_src), .prefixed(d2_prefixed),
        .pfx_pending(d2_pfx_pending), .pfx_overwrite(d2_pfx_overwrite)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Immediate value from the rules in arithmetic form: field = bits above
    // the LSB modulo 2^17; prefix = P*2^17 + field; sign-extension adds
    // 2^32 - 2^17 when the field's top bit is set.
    function automatic logic [31:0] model_imm(input logic [31:0] ins, input bit z,
                                              input bit hold, input logic [14:0] p);
        longint unsigned f;
        longint unsigned r;
        f = (ins[27] ? longint'(ins) : longint'(ins)) % 131072;
        if (hold)
            r = (longint'(p) * 131072 + f) % 64'd4294967296;
        else if (!z && f >= 65536)
            r = f + 64'd4294967296 - 131072;
        else
            r = f;
        return r[31:0];
    endfunction

    logic        m_valid, m_src, m_pre, m_hold, m_ovw;
    logic [31:0] m_imm;
    logic [14:0] m_pfx;
    wire         m_acc  = in_valid && (!m_valid || out_ready) && !flush;
    wire         m_xfer = m_valid && out_ready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 0; m_src <= 0; m_pre <= 0; m_hold <= 0; m_ovw <= 0;
            m_imm <= 0; m_pfx <= 0;
        end else if (flush) begin
            m_valid <= 0; m_hold <= 0; m_ovw <= 0;
        end else begin
            m_ovw <= m_acc && is_prefix && m_hold;
            if (m_acc && is_prefix) begin
                m_hold  <= 1;
                m_pfx   <= instr[14:0];
                m_valid <= m_valid && !m_xfer;
            end else if (m_acc) begin
                m_valid <= 1;
                m_imm   <= model_imm(instr, zext, m_hold, m_pfx);
                m_src   <= instr[27];
                m_pre   <= m_hold;
                m_hold  <= 0;
            end else if (m_xfer) begin
                m_valid <= 0;
            end
        end
    end

    // Cycle-by-cycle comparison of the default instance against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("cmp_out_valid", out_valid, m_valid);
            chk("cmp_imm_out", imm_out, m_imm);
            chk("cmp_imm_src", imm_src, m_src);
            chk("cmp_prefixed", prefixed, m_pre);
            chk("cmp_pfx_pending", pfx_pending, m_hold);
            chk("cmp_pfx_overwrite", pfx_overwrite, m_ovw);
            chk("cmp_in_ready", in_ready, !m_valid || out_ready);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic v, input logic [31:0] ins, input logic p,
                        input logic z, input logic r, input logic f);
        in_valid = v; instr = ins; is_prefix = p; zext = z; out_ready = r; flush = f;
        @(posedge clk);
        #1;
        $display("txn v=%0b instr=%h pfx=%0b zext=%0b rdy=%0b flush=%0b -> ov=%0b imm=%h src=%0b pre=%0b pend=%0b ovw=%0b",
                 v, ins, p, z, r, f, out_valid, imm_out, imm_src, prefixed, pfx_pending, pfx_overwrite);
    endtask

    task automatic rst_pulse();
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_imm_out", imm_out, 0);
        chk("arst_pfx_pending", pfx_pending, 0);
        chk("arst_prefixed", prefixed, 0);
        #1 rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_imm_out", imm_out, 0);
        chk("reset_pfx_pending", pfx_pending, 0);
        chk("reset_pfx_overwrite", pfx_overwrite, 0);
        rst = 1'b0;

        // Sign- and zero-extension of an all-ones I field.
        step(1, 32'h0001_FFFF, 0, 0, 1, 0);
        chk("sext_valid", out_valid, 1);
        chk("sext_imm", imm_out, 32'hFFFF_FFFF);
        chk("sext_prefixed", prefixed, 0);
        step(1, 32'h0001_FFFF, 0, 1, 1, 0);
        chk("zext_imm", imm_out, 32'h0001_FFFF);

        // Field selection on the I_LSB=4 instance.
        step(1, 32'h0800_0123, 0, 0, 1, 0);
        chk("mem_field_imm", d2_imm_out, 32'h0000_0123);
        chk("mem_field_src", d2_imm_src, 1);
        step(1, 32'h0000_0123, 0, 0, 1, 0);
        chk("i_field_imm", d2_imm_out, 32'h0000_0012);
        chk("i_field_src", d2_imm_src, 0);

        // Prefix followed by an I-type instruction.
        step(1, 32'h0000_1234, 1, 0, 1, 0);
        chk("pfx_no_valid", out_valid, 0);
        chk("pfx_pending_set", pfx_pending, 1);
        step(1, 32'h0000_0ABC, 0, 0, 1, 0);
        chk("pfx_imm", imm_out, 32'h2468_0ABC);
        chk("pfx_prefixed", prefixed, 1);
        chk("pfx_pending_clr", pfx_pending, 0);

        // Back-to-back prefixes: second one overwrites.
        step(1, 32'h0000_0001, 1, 0, 1, 0);
        chk("ovw_first", pfx_overwrite, 0);
        step(1, 32'h0000_0002, 1, 0, 1, 0);
        chk("ovw_pulse", pfx_overwrite, 1);
        step(1, 32'h0000_0000, 0, 1, 1, 0);
        chk("ovw_imm", imm_out, 32'h0004_0000);
        chk("ovw_drop", pfx_overwrite, 0);

        // Backpressure: hold a result for three cycles.
        step(1, 32'h0000_0055, 0, 0, 1, 0);
        chk("bp_first", imm_out, 32'h0000_0055);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h0000_0066, 0, 0, 0, 0);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_stable", imm_out, 32'h0000_0055);
            chk("bp_valid", out_valid, 1);
        end
        step(1, 32'h0000_0066, 0, 0, 1, 0);
        chk("bp_next_imm", imm_out, 32'h0000_0066);
        chk("bp_next_valid", out_valid, 1);
        step(0, 32'h0, 0, 0, 1, 0);
        chk("bp_drain", out_valid, 0);

        // Flush while holding a prefix.
        step(1, 32'h0000_0007, 1, 0, 1, 0);
        chk("fl_hold", pfx_pending, 1);
        step(1, 32'h0000_0099, 0, 0, 1, 1);
        chk("fl_valid", out_valid, 0);
        chk("fl_pending", pfx_pending, 0);
        chk("fl_imm_kept", imm_out, 32'h0000_0066);
        step(1, 32'h0001_FFFF, 0, 0, 1, 0);
        chk("fl_idle_imm", imm_out, 32'hFFFF_FFFF);
        chk("fl_idle_pre", prefixed, 0);

        // Asynchronous reset with a stalled result.
        step(1, 32'h0000_0005, 0, 0, 1, 0);
        step(0, 32'h0, 0, 0, 0, 0);
        chk("stall_valid", out_valid, 1);
        rst_pulse();

        // Asynchronous reset while holding a prefix.
        step(1, 32'h0000_0003, 1, 0, 1, 0);
        chk("hold_before_rst", pfx_pending, 1);
        rst_pulse();
        step(1, 32'h0001_0000, 0, 0, 1, 0);
        chk("post_rst_imm", imm_out, 32'hFFFF_0000);
        chk("post_rst_pre", prefixed, 0);
        step(0, 32'h0, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
